seg_scan_reader: RTL
====================

# seg_scan_reader

Receive-side counterpart of the multiplexed six-digit display driver: samples the scanned `seg_disp`/`seg_sel` bus, decodes each active digit's 7-segment pattern back to a hex nibble, and reassembles the 24-bit display word. It updates its output only after a configurable number of identical consecutive frames. It is used for display loopback checking and board self-test, and sits beside the display driver on the `clk1k` domain.

## Interface
- `STABLE_FRAMES`, default 2: identical consecutive complete frames required before `seg_out` updates. Legal range is 1–15.
- `clk1k` in 1: scan clock, the same 1 kHz clock that drives the display driver.
- `clr` in 1: asynchronous, active-high reset.
- `seg_disp` in 8: segment bus, active-low. Bit [7] = dp; bits [6:0] = g..a.
- `seg_sel` in 6: digit select, active-low one-hot. Bit [i] selects digit i; digit 0 is rightmost and maps to `seg_out[3:0]`.
- `seg_out` out 24: last stable decoded word. Digit i occupies bits [4i+3:4i].
- `dp_out` out 6: last stable dp state per digit, active-high.
- `blank_out` out 6: last stable per-digit blank flag.
- `stable` out 1: level. High while the current run of identical frames is ≥ `STABLE_FRAMES`.
- `upd` out 1: one-cycle pulse when `seg_out`/`dp_out`/`blank_out` are written.
- `err` out 1: one-cycle pulse on an illegal select or segment pattern.
- `err_cnt` out 8: saturating count of `err` pulses (holds at 255).

## Operation
- **Input register.** Inputs are registered once (`in_q`) and then inverted to active-high internally.
- **Select decode on `in_q`.**
  - All-zero select is a blanking gap: ignored, no state change.
  - Exactly one bit set gives index i.
  - More than one bit set is an error.
- **Segment decode (g..a, active-high).**
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Letters: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 decodes to nibble 0 with blank=1.
  - Any other pattern is an error.
  - dp is captured unconditionally.
- **Capture.** A valid digit writes `shadow[i]` (nibble, dp, blank) and sets `mask[i]`.
  - A repeated index before the frame completes overwrites that digit; it is not an error.
- **Frame complete.** When `mask` reaches 6'b111111:
  - Compare `shadow` against `last_frame` (all 36 bits).
  - If equal, `run` increments, saturating at 15. Otherwise `run` is set to 1.
  - `last_frame` is loaded with `shadow` and `mask` is cleared.
- **Publish.** When the new `run` equals `STABLE_FRAMES` exactly, `seg_out`/`dp_out`/`blank_out` load `shadow` and `upd` pulses.
  - `stable` is set to (new `run` ≥ `STABLE_FRAMES`).
  - A mismatching frame clears `stable`, unless `STABLE_FRAMES`=1, in which case it republishes immediately.
- **Error.** On an illegal select or pattern:
  - `err` pulses and `err_cnt` increments, saturating.
  - `mask` clears, `run` is set to 0, and `stable` clears.
  - `seg_out`/`dp_out`/`blank_out` hold their last stable values.
- **Reset mid-frame.** All state clears immediately and asynchronously; partial frames are discarded.

## Timing
- **Reset values.** `seg_out`=0, `dp_out`=0, `blank_out`=0, `stable`=0, `upd`=0, `err`=0, `err_cnt`=0. Internal `mask`, `run`, `last_frame` and `shadow` are also 0.
- **Pipeline.** For a digit presented before edge k:
  - edge k: sampled into `in_q`.
  - edge k+1: `shadow`/`mask` written, or `err` asserted.
  - edge k+2: frame evaluation, writing `run`, `last_frame`, `seg_out`, `stable`, `upd`.
- **Publish latency.** `upd` rises 2 edges after the edge that samples the frame's last digit.
- **Same-edge errors.** An error at edge k+1 while a frame evaluation is pending at the same edge: the error wins. `run`=0, `stable`=0, no `upd`.
- **Capture after completion.** A digit captured on the same edge the mask is cleared (k+2) belongs to the next frame. The mask clear applies first, then the new bit sets.
- **No handshake.** The bus is sampled every cycle; the source never stalls.

## Test plan
- **Steady scan.** Scan word 24'h123456 with no dp, one digit per cycle, rightmost first, for 3 frames. Expected: `upd` exactly once, at the end of frame 2 plus 2 edges; `seg_out`=24'h123456; `stable`=1; `err_cnt`=0.
- **Word change.** After the steady scan, switch to 24'h0A0B0C with dp on digit 5. Expected: `stable` drops after the first new frame; `seg_out`/`dp_out`/`upd` follow the second new frame: `seg_out`=24'h0A0B0C, `dp_out`=6'b100000, one `upd`.
- **Blank and gap handling.** Insert sel=6'b111111 gap cycles between digits and scan digit 3 with pattern 00. Expected: no errors; `blank_out`=6'b001000; nibble 3 = 0.
- **Illegal patterns.** Mid-frame, drive sel=6'b111100 (two digits active), then segment pattern 7'h01. Expected: two `err` pulses; `err_cnt`=2; `stable`=0; `seg_out` unchanged; recovery after `STABLE_FRAMES` clean frames.
- **Error counter saturation.** Drive 300 consecutive illegal cycles. Expected: `err_cnt` holds at 255.
- **Reset during a partial frame.** Assert `clr` asynchronously mid-frame (between edges). Expected: all outputs 0 immediately; the next full frame alone does not publish when `STABLE_FRAMES`=2.

Source files
------------

// File: rtl/seg_scan_reader.sv
// -----------------------------------------------------------------------------
// seg_scan_reader
//
// Purpose: listens to a multiplexed six-digit 7-segment scan bus. Each active
// digit's segment pattern is decoded back to a hex nibble, and the 24-bit
// display word is reassembled from it. The word is published only after
// STABLE_FRAMES identical consecutive complete frames. Illegal selects or
// patterns pulse err and bump a saturating error counter.
//
// Ports:
//   clk1k      in   1  scan clock (same clock as the display driver)
//   clr        in   1  asynchronous active-high reset
//   seg_disp   in   8  segment bus, active-low, [7]=dp, [6:0]=g..a
//   seg_sel    in   6  digit select, active-low one-hot, bit i = digit i
//   seg_out    out 24  last stable word, digit i at [4i+3:4i]
//   dp_out     out  6  last stable dp per digit, active-high
//   blank_out  out  6  last stable blank flag per digit
//   stable     out  1  level: current identical-frame run >= STABLE_FRAMES
//   upd        out  1  one-cycle pulse when the published outputs are written
//   err        out  1  one-cycle pulse on an illegal select or pattern
//   err_cnt    out  8  saturating count of err pulses
//
// Handshake: none. The bus is sampled on every clock edge and the source
// never stalls; there is no valid/ready pair on either side.
// -----------------------------------------------------------------------------
module seg_scan_reader #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk1k,
    input  logic        clr,
    input  logic [7:0]  seg_disp,
    input  logic [5:0]  seg_sel,
    output logic [23:0] seg_out,
    output logic [5:0]  dp_out,
    output logic [5:0]  blank_out,
    output logic        stable,
    output logic        upd,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [3:0] RUN_MAX  = 4'd15;

    // Input register. Holds the bus already inverted to active-high, so the
    // cleared value is the idle bus (no digit selected, all segments off).
    logic [7:0]       disp_q;
    logic [5:0]       sel_q;

    // Frame being assembled.
    logic [5:0][3:0]  shadow_nib;
    logic [5:0]       shadow_dp;
    logic [5:0]       shadow_blank;
    logic [5:0]       mask;

    // Previous complete frame and length of the identical-frame run.
    logic [35:0]      last_frame;
    logic [3:0]       run;

    // Decode results for the registered sample.
    logic [2:0]       sel_ones;
    logic [2:0]       sel_idx;
    logic             seg_ok;
    logic             seg_blank;
    logic [3:0]       seg_nib;
    logic             capture;
    logic             bad;
    logic             frame_done;
    logic             frame_same;
    logic [35:0]      shadow_vec;
    logic [3:0]       run_next;
    logic [5:0]       mask_next;

    always_ff @(posedge clk1k or posedge clr) begin
        if (clr) begin
            disp_q <= '0;
            sel_q  <= '0;
        end else begin
            disp_q <= ~seg_disp;
            sel_q  <= ~seg_sel;
        end
    end

    // Count active selects and remember the index of the (last) active one.
    always_comb begin
        sel_ones = '0;
        sel_idx  = '0;
        for (int i = 0; i < 6; i++) begin
            if (sel_q[i]) begin
                sel_ones = sel_ones + 3'd1;
                sel_idx  = 3'(i);
            end
        end
    end

    always_comb begin
        seg_ok    = 1'b1;
        seg_blank = 1'b0;
        seg_nib   = 4'h0;
        case (disp_q[6:0])
            7'h3F:   seg_nib = 4'h0;
            7'h06:   seg_nib = 4'h1;
            7'h5B:   seg_nib = 4'h2;
            7'h4F:   seg_nib = 4'h3;
            7'h66:   seg_nib = 4'h4;
            7'h6D:   seg_nib = 4'h5;
            7'h7D:   seg_nib = 4'h6;
            7'h07:   seg_nib = 4'h7;
            7'h7F:   seg_nib = 4'h8;
            7'h6F:   seg_nib = 4'h9;
            7'h77:   seg_nib = 4'hA;
            7'h7C:   seg_nib = 4'hB;
            7'h39:   seg_nib = 4'hC;
            7'h5E:   seg_nib = 4'hD;
            7'h79:   seg_nib = 4'hE;
            7'h71:   seg_nib = 4'hF;
            7'h00:   seg_blank = 1'b1;
            default: seg_ok = 1'b0;
        endcase
    end

    always_comb begin
        capture    = (sel_ones == 3'd1) && seg_ok;
        bad        = (sel_ones > 3'd1) || ((sel_ones == 3'd1) && !seg_ok);
        frame_done = &mask;
        shadow_vec = {shadow_blank, shadow_dp, shadow_nib};
        frame_same = (shadow_vec == last_frame);
        if (!frame_same) begin
            run_next = 4'd1;
        end else if (run == RUN_MAX) begin
            run_next = RUN_MAX;
        end else begin
            run_next = run + 4'd1;
        end
        // A completed frame's mask clears first; a digit captured on the
        // same edge then starts the next frame.
        mask_next = frame_done ? 6'b0 : mask;
        if (capture) begin
            mask_next[sel_idx] = 1'b1;
        end
        if (bad) begin
            mask_next = '0;
        end
    end

    always_ff @(posedge clk1k or posedge clr) begin
        if (clr) begin
            shadow_nib   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            mask         <= '0;
            last_frame   <= '0;
            run          <= '0;
            seg_out      <= '0;
            dp_out       <= '0;
            blank_out    <= '0;
            stable       <= 1'b0;
            upd          <= 1'b0;
            err          <= 1'b0;
            err_cnt      <= '0;
        end else begin
            upd  <= 1'b0;
            err  <= bad;
            mask <= mask_next;

            if (capture) begin
                shadow_nib[sel_idx]   <= seg_nib;
                shadow_dp[sel_idx]    <= disp_q[7];
                shadow_blank[sel_idx] <= seg_blank;
            end

            if (bad) begin
                // An error outranks a frame evaluation on the same edge.
                run    <= '0;
                stable <= 1'b0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (frame_done) begin
                last_frame <= shadow_vec;
                run        <= run_next;
                stable     <= (run_next >= STABLE_N);
                if (run_next == STABLE_N) begin
                    seg_out   <= shadow_nib;
                    dp_out    <= shadow_dp;
                    blank_out <= shadow_blank;
                    upd       <= 1'b1;
                end
            end
        end
    end

endmodule
